// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the main-memory port arbiter.
// The I and D cache controllers are the two requesters; one transaction
// is in flight on the memory port at any time.
package mem_arb_pkg;

    // Default widths for a 10-bit address (tag 3, index 5, offset 2).
    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 32;
    localparam int LINE_W_DEF  = 128;

    // Watchdog: maximum BUSY cycles without mem_ready, held in an 8-bit counter.
    localparam int TIMEOUT_DEF = 255;
    localparam int WD_W        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_picker.sv
// Two-way round-robin choice between the I and D requesters.
// When both request, the side that did not win last time is chosen;
// a single requester always wins.
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  owner_e last_grant,
    output logic   grant_valid,
    output owner_e grant_owner
);

    // Pick the owner of the next transaction from the current requests.
    always_comb begin
        grant_valid = i_req | d_req;
        grant_owner = OWN_I;
        if (i_req && d_req) begin
            grant_owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Main-memory port arbiter shared by the I-cache and D-cache controllers.
// IDLE grants a requester, BUSY holds the command on the memory port until
// mem_ready (or watchdog expiry), RESP pulses the owner's ready for one cycle.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LINE_W  = LINE_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,

    output logic [LINE_W-1:0] rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_ready,

    output logic              timeout_err
);

    // Watchdog fires on the TIMEOUT-th BUSY cycle (count starts at 0).
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    owner_e              r_owner;
    owner_e              r_last_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [LINE_W-1:0]   r_rdata;
    logic [WD_W-1:0]     r_wd_cnt;
    logic                r_timeout_err;

    logic                w_grant_valid;
    owner_e              w_grant_owner;
    logic                w_grant;
    logic                w_done;
    logic                w_expire;

    rr_picker u_rr_picker (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    // Next-state decode: grant in IDLE, complete or time out in BUSY, one RESP cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_done      = 1'b0;
        w_expire    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (r_wd_cnt == WD_LAST) begin
                    w_expire    = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch owner, command and address at grant; they stay fixed through BUSY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= OWN_I;
            r_last_grant <= OWN_I;
            r_we         <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else if (w_grant) begin
            r_owner      <= w_grant_owner;
            r_last_grant <= w_grant_owner;
            if (w_grant_owner == OWN_D) begin
                r_we       <= d_we;
                r_mem_addr <= d_addr;
                if (d_we) begin
                    r_mem_wdata <= d_wdata;
                end
            end else begin
                r_we       <= 1'b0;
                r_mem_addr <= i_addr;
            end
        end
    end

    // Watchdog counter: cleared at grant, advances every BUSY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (w_grant) begin
            r_wd_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Capture the returned line, or zero it and raise the sticky error on expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata       <= '0;
            r_timeout_err <= 1'b0;
        end else if (w_done) begin
            r_rdata <= mem_rdata;
        end else if (w_expire) begin
            r_rdata       <= '0;
            r_timeout_err <= 1'b1;
        end
    end

    // Strobes and ready pulses decode straight from the registered state,
    // so an asynchronous reset drops them without waiting for a clock edge.
    assign mem_read    = (r_state == BUSY) && !r_we;
    assign mem_write   = (r_state == BUSY) &&  r_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign i_ready     = (r_state == RESP) && (r_owner == OWN_I);
    assign d_ready     = (r_state == RESP) && (r_owner == OWN_D);
    assign rdata       = r_rdata;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table of single-side transactions, then
// hand-written sequences for tie/fairness, stray mem_ready, watchdog and
// asynchronous reset in BUSY. A queue holds the expected completion of each
// transaction from the moment its request is driven.
module tb_mem_port_arbiter;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_req = 1'b0;
    logic [9:0]    i_addr = '0;
    logic          i_ready;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [9:0]    d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_ready;
    logic [127:0]  rdata;
    logic          mem_read;
    logic          mem_write;
    logic [9:0]    mem_addr;
    logic [31:0]   mem_wdata;
    logic [127:0]  mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          timeout_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit           is_d;
        bit           we;
        logic [9:0]   addr;
        logic [31:0]  wdata;
        int           lat;
        logic [127:0] line;
        bit           exp_rd;
        bit           exp_wr;
        bit           chk_line;
    } vec_t;

    typedef struct {
        bit           is_d;
        logic [127:0] line;
        bit           chk_line;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vt[6];

    mem_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_ready     (i_ready),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_ready     (d_ready),
        .rdata       (rdata),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%b exp=%b", nm, act, exp);
        end
    endtask

    // Called on the cycle a completion is expected: pop and compare.
    task automatic check_resp(input string nm);
        sb_t e;
        chk1({nm, "_ready_seen"}, i_ready | d_ready, 1'b1);
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb_empty act=0 exp=1", nm);
        end else begin
            e = sb_q.pop_front();
            chk1({nm, "_i_ready"}, i_ready, !e.is_d);
            chk1({nm, "_d_ready"}, d_ready, e.is_d);
            if (e.chk_line) chk({nm, "_rdata"}, rdata, e.line);
        end
        chk1({nm, "_resp_rd"}, mem_read, 1'b0);
        chk1({nm, "_resp_wr"}, mem_write, 1'b0);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        i_req     = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // One single-side transaction; entered and left on a negedge in IDLE.
    task automatic do_txn(input vec_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        sb_q.push_back('{v.is_d, v.line, v.chk_line});
        for (int c = 0; c < v.lat; c++) begin
            @(negedge clk);
            // Inputs other than req may wander once granted.
            d_addr  = ~v.addr;
            d_wdata = ~v.wdata;
            d_we    = ~v.we;
            i_addr  = ~v.addr;
            chk1({nm, "_rd"}, mem_read, v.exp_rd);
            chk1({nm, "_wr"}, mem_write, v.exp_wr);
            chk({nm, "_addr"}, 128'(mem_addr), 128'(v.addr));
            if (v.exp_wr) chk({nm, "_wdata"}, 128'(mem_wdata), 128'(v.wdata));
            chk1({nm, "_early_rdy"}, i_ready | d_ready, 1'b0);
            if (c == v.lat - 1) begin
                mem_ready = 1'b1;
                mem_rdata = v.line;
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = {4{32'h5A5A_A5A5}};
        check_resp(nm);
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        chk1({nm, "_idle_rdy"}, i_ready | d_ready, 1'b0);
        chk1({nm, "_idle_strb"}, mem_read | mem_write, 1'b0);
    endtask

    initial begin
        int busy_cnt;
        bit early_err;
        logic [127:0] ln;

        vt[0] = '{1'b1, 1'b0, 10'h2A4, 32'h0000_0000, 2, 128'hDEADBEEF_0000_1111_2222_3333, 1'b1, 1'b0, 1'b1};
        vt[1] = '{1'b1, 1'b1, 10'h015, 32'h1234_5678, 1, 128'h0,                           1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b0, 10'h3FC, 32'h0000_0000, 1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b1, 1'b0, 1'b1};
        vt[3] = '{1'b0, 1'b0, 10'h001, 32'h0000_0000, 4, 128'hFFFF_FFFF_0000_0000_FFFF_FFFF_0000_0001, 1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b1, 1'b0, 10'h155, 32'h0000_0000, 3, 128'hCAFE_F00D_1357_9BDF_2468_ACE0_1111_2222, 1'b1, 1'b0, 1'b1};
        vt[5] = '{1'b1, 1'b1, 10'h3FF, 32'hFFFF_FFFF, 5, 128'h0,                           1'b0, 1'b1, 1'b0};

        // Reset state
        @(negedge clk);
        chk1("rst_i_ready", i_ready, 1'b0);
        chk1("rst_d_ready", d_ready, 1'b0);
        chk1("rst_rd", mem_read, 1'b0);
        chk1("rst_wr", mem_write, 1'b0);
        chk("rst_addr", 128'(mem_addr), 128'h0);
        chk("rst_wdata", 128'(mem_wdata), 128'h0);
        chk("rst_rdata", rdata, 128'h0);
        chk1("rst_err", timeout_err, 1'b0);
        apply_reset();

        // Table-driven single-side transactions
        for (int i = 0; i < 6; i++) begin
            do_txn(vt[i], i);
        end

        // Watchdog: no mem_ready; rdata still holds a nonzero earlier line
        mem_rdata = {4{32'h7777_8888}};
        i_req  = 1'b1;
        i_addr = 10'h0AB;
        sb_q.push_back('{1'b0, 128'h0, 1'b1});
        busy_cnt  = 0;
        early_err = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!mem_read) break;
            busy_cnt++;
            if (timeout_err) early_err = 1'b1;
        end
        chk("wd_busy_cycles", 128'(busy_cnt), 128'd255);
        chk1("wd_no_early_err", early_err, 1'b0);
        chk1("wd_err_set", timeout_err, 1'b1);
        check_resp("wd");
        i_req = 1'b0;
        @(negedge clk);
        do_txn(vt[0], 10);
        chk1("wd_err_sticky", timeout_err, 1'b1);
        apply_reset();
        chk1("wd_err_cleared", timeout_err, 1'b0);

        // mem_ready while IDLE is ignored
        mem_ready = 1'b1;
        mem_rdata = '1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk1("idle_mr_rdy", i_ready | d_ready, 1'b0);
        chk1("idle_mr_strb", mem_read | mem_write, 1'b0);
        chk("idle_mr_rdata", rdata, 128'h0);
        @(negedge clk);
        chk1("idle_mr_rdy2", i_ready | d_ready, 1'b0);
        chk1("idle_mr_strb2", mem_read | mem_write, 1'b0);

        // Tie from reset: D first, then strict alternation
        apply_reset();
        i_req = 1'b1; i_addr = 10'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h200;
        for (int k = 0; k < 6; k++) begin
            bit exp_d;
            exp_d = (k % 2) == 0;
            ln = {4{32'hC0DE_0000 + 32'(k)}};
            sb_q.push_back('{exp_d, ln, 1'b1});
            @(negedge clk);
            chk1($sformatf("tie%0d_rd", k), mem_read, 1'b1);
            chk($sformatf("tie%0d_addr", k), 128'(mem_addr), exp_d ? 128'h200 : 128'h100);
            mem_ready = 1'b1;
            mem_rdata = ln;
            @(negedge clk);
            mem_ready = 1'b0;
            check_resp($sformatf("tie%0d", k));
            if (d_ready) d_req = 1'b0;
            if (i_ready) i_req = 1'b0;
            @(negedge clk);
            chk1($sformatf("tie%0d_idle", k), mem_read | mem_write, 1'b0);
            i_req = 1'b1;
            d_req = 1'b1;
        end
        i_req = 1'b0;
        d_req = 1'b0;

        // Asynchronous reset in the middle of BUSY
        apply_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h2A4;
        @(negedge clk);
        chk1("arst_busy_rd", mem_read, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk1("arst_rd_drop", mem_read, 1'b0);
        chk1("arst_wr_drop", mem_write, 1'b0);
        d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1($sformatf("arst_no_rdy%0d", c), i_ready | d_ready, 1'b0);
            chk1($sformatf("arst_idle%0d", c), mem_read | mem_write, 1'b0);
        end
        chk("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction-cache controller (I side) and the data-cache controller (D side).
- The main-memory port provides a block read (128-bit line), a word write-through (32-bit) and a `ready` completion signal.
- Round-robin arbitration between the two sides; one transaction is outstanding at a time.
- The block sits between the two cache controllers and the data memory, above the data-memory subsystem.

Parameters:
- ADDR_W, 10, byte/word address width presented to main memory (tag 3, index 5, offset 2).
- DATA_W, 32, write-through word width.
- LINE_W, 128, cache line width returned on block read.
- TIMEOUT, 255, max cycles to wait for `mem_ready` before flagging an error (8-bit counter).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  I side request, level; held until `i_ready`.
- i_addr  in  ADDR_W  I side line address.
- i_ready  out  1  one-cycle completion pulse to I side.
- d_req  in  1  D side request, level; held until `d_ready`.
- d_we  in  1  D side: 1 = word write, 0 = line read.
- d_addr  in  ADDR_W  D side address.
- d_wdata  in  DATA_W  D side write word.
- d_ready  out  1  one-cycle completion pulse to D side.
- rdata  out  LINE_W  registered line data; valid while `i_ready` or `d_ready` is high.
- mem_read  out  1  block read strobe to main memory.
- mem_write  out  1  word write strobe to main memory.
- mem_addr  out  ADDR_W  registered address to main memory.
- mem_wdata  out  DATA_W  registered write word.
- mem_rdata  in  LINE_W  line from main memory; valid with `mem_ready`.
- mem_ready  in  1  main memory completion.
- timeout_err  out  1  sticky; set on watchdog expiry.

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, `last_grant` = I (so D wins the first tie), watchdog count 0. Asserting `reset` mid-transaction drops `mem_read`/`mem_write` immediately; the in-flight transaction is abandoned and no ready pulse is produced.
- State IDLE:
  - No request: stay in IDLE.
  - Only one side requesting: grant it.
  - Both requesting: grant the side not equal to `last_grant`.
  - On grant: register `owner`, `mem_addr`, `mem_wdata` (D only) and the command; update `last_grant`; go to BUSY.
- State BUSY:
  - `mem_read` = 1 for an I grant or a D read; `mem_write` = 1 for a D write. The two strobes are never high together.
  - Both strobes and the registered address are held constant for the whole of BUSY.
  - When `mem_ready` = 1: capture `mem_rdata` into `rdata` (also on writes, where the value is don't-care); go to RESP.
  - `mem_ready` seen in IDLE or RESP is ignored.
- State RESP (exactly one cycle):
  - Strobes are 0; the owner's ready output is 1; then go to IDLE.
  - The requester must drop its req at the same edge it samples ready, so the next IDLE cycle does not re-grant a stale request.
- Latency: grant edge → BUSY; minimum request-to-ready is 3 cycles when `mem_ready` returns in the first BUSY cycle.
- Watchdog:
  - The counter increments every BUSY cycle.
  - On reaching TIMEOUT without `mem_ready`: set `timeout_err`, force a completion (ready pulse with `rdata` = 0), go to RESP.
  - `timeout_err` clears only on reset.
- Requests changing while not granted are sampled fresh in each IDLE cycle. `d_we`, `d_addr` and `d_wdata` need only be stable in the grant cycle.
- Fairness: under continuous requests from both sides, grants strictly alternate I/D.

Decomposition:
- Package `mem_arb_pkg` holds:
  - the state enum (IDLE, BUSY, RESP);
  - the owner encoding (OWN_I = 0, OWN_D = 1);
  - the ADDR_W/DATA_W/LINE_W defaults and the TIMEOUT default.
- One sub-module, `rr_picker`: combinational two-way round-robin choice from `i_req`, `d_req` and `last_grant`. Outputs `grant_valid` and `grant_owner`.

Test Plan:
- D read alone: `d_req`=1, `d_we`=0, `d_addr`=0x2A4; memory returns 0xDEADBEEF_0000_1111_2222_3333 after 2 BUSY cycles → `mem_read` high 2 cycles with `mem_addr`=0x2A4; `d_ready` pulses one cycle with `rdata` equal to that line; `i_ready` stays 0.
- D write: `d_we`=1, `d_addr`=0x015, `d_wdata`=0x12345678 → `mem_write`=1 and `mem_read`=0 throughout BUSY, `mem_wdata`=0x12345678; `d_ready` pulse after `mem_ready`.
- Tie from reset: `i_req` and `d_req` both high in cycle 1 → D granted first, then I; over 6 back-to-back transactions the grants alternate D, I, D, I, D, I.
- Mid-operation changes: `d_addr` changes during BUSY → `mem_addr` unchanged. `mem_ready` pulse while IDLE → no ready output, no state change.
- Watchdog: `mem_ready` held 0 → after 255 BUSY cycles, `timeout_err`=1, owner ready pulse with `rdata`=0; the error flag persists across subsequent transactions until reset.
- Reset mid-BUSY: assert `reset` asynchronously between edges → `mem_read` drops immediately without waiting for a clock edge; after reset release, state is IDLE and no ready pulse is emitted for the abandoned request.
